bonsai_run_loader: RTL and testbench

- Upstream feeder for the two-input merger: accepts one 32-bit key stream (valid/ready) from the memory read path, cuts it into sorted runs of RUN_LEN keys, appends a zero terminator after each run, and steers runs alternately into lane A and lane B.
- Each lane is a show-ahead FIFO whose data/empty/read signals connect directly to the merger's i_fifo_1 and i_fifo_2 ports.
- Key value 0 is reserved as the run terminator throughout the sorter.

---
 rtl/bonsai_pkg.sv | 11 +
 rtl/bonsai_lane_fifo.sv | 54 +++++
 rtl/bonsai_run_loader.sv | 127 ++++++++++++
 tb/tb_bonsai_run_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bonsai_pkg.sv
// Shared types and constants for the bonsai sorter front end.
// Key 0 is the run terminator everywhere in the sorter.
package bonsai_pkg;
    localparam int KEY_W = 32;
    localparam logic [KEY_W-1:0] TERMINATOR = '0;

    typedef enum logic {
        FILL = 1'b0,
        TERM = 1'b1
    } state_t;
endpackage

// File: rtl/bonsai_lane_fifo.sv
// Show-ahead synchronous FIFO: head data valid whenever o_empty is low.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: o_full blocks i_enq; i_deq on an empty FIFO is ignored.
module bonsai_lane_fifo
    import bonsai_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = KEY_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enq,
    input  logic             i_deq,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign w_push  = i_enq & ~o_full;
    assign w_pop   = i_deq & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/bonsai_run_loader.sv
// Cuts one key stream into zero-terminated runs, steered alternately to lanes A/B.
// Latency: an accepted key reaches its lane head on the next cycle.
// Backpressure: o_ready drops in TERM and whenever the current lane is full.
module bonsai_run_loader
    import bonsai_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [KEY_W-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    output logic [KEY_W-1:0] o_fifo_1,
    output logic             o_fifo_1_empty,
    input  logic             i_fifo_1_read,
    output logic [KEY_W-1:0] o_fifo_2,
    output logic             o_fifo_2_empty,
    input  logic             i_fifo_2_read,
    output logic [CNT_W-1:0] o_runs_done,
    output logic             o_lane
);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0]    RUN_LAST = RW'(RUN_LEN);
    localparam logic [RW-1:0]    RUN_ONE  = 1;
    localparam logic [CNT_W-1:0] RUNS_ONE = 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RW-1:0]    r_count;
    logic [RW-1:0]    w_count_nxt;
    logic [RW-1:0]    w_count_inc;
    logic             r_lane;
    logic             w_lane_nxt;
    logic [CNT_W-1:0] r_runs;
    logic [CNT_W-1:0] w_runs_nxt;
    logic             w_wr_en;
    logic [KEY_W-1:0] w_wr_dat;
    logic             w_full_a;
    logic             w_full_b;
    logic             w_full_cur;
    logic             w_xfer;

    assign w_full_cur  = r_lane ? w_full_b : w_full_a;
    assign o_ready     = (r_state == FILL) & ~w_full_cur & ~i_rst;
    assign w_xfer      = i_valid & o_ready;
    assign o_runs_done = r_runs;
    assign o_lane      = r_lane;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_lane_nxt  = r_lane;
        w_runs_nxt  = r_runs;
        w_wr_en     = 1'b0;
        w_wr_dat    = i_data;
        w_count_inc = r_count + RUN_ONE;
        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    w_wr_en = 1'b1;
                    if (i_data == TERMINATOR) begin
                        // An explicit zero closes the run itself; a flush alongside it adds nothing.
                        w_count_nxt = '0;
                        w_lane_nxt  = ~r_lane;
                        w_runs_nxt  = r_runs + RUNS_ONE;
                    end else begin
                        w_count_nxt = w_count_inc;
                        if ((w_count_inc == RUN_LAST) || i_flush) w_state_nxt = TERM;
                    end
                end else if (i_flush && (r_count != '0)) begin
                    w_state_nxt = TERM;
                end
            end
            TERM: begin
                if (!w_full_cur) begin
                    w_wr_en     = 1'b1;
                    w_wr_dat    = TERMINATOR;
                    w_count_nxt = '0;
                    w_lane_nxt  = ~r_lane;
                    w_runs_nxt  = r_runs + RUNS_ONE;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FILL;
            r_count <= '0;
            r_lane  <= 1'b0;
            r_runs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_lane  <= w_lane_nxt;
            r_runs  <= w_runs_nxt;
        end
    end

    bonsai_lane_fifo #(.DEPTH(DEPTH), .WIDTH(KEY_W)) u_lane_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_enq   (w_wr_en & ~r_lane),
        .i_deq   (i_fifo_1_read),
        .i_data  (w_wr_dat),
        .o_data  (o_fifo_1),
        .o_empty (o_fifo_1_empty),
        .o_full  (w_full_a)
    );

    bonsai_lane_fifo #(.DEPTH(DEPTH), .WIDTH(KEY_W)) u_lane_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_enq   (w_wr_en & r_lane),
        .i_deq   (i_fifo_2_read),
        .i_data  (w_wr_dat),
        .o_data  (o_fifo_2),
        .o_empty (o_fifo_2_empty),
        .o_full  (w_full_b)
    );
endmodule

// File: tb/tb_bonsai_run_loader.sv
// Directed vector bench for bonsai_run_loader (DEPTH=16 main instance, DEPTH=4 stall instance).
module tb_bonsai_run_loader;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, flush, rd1, rd2;
    logic [31:0] data;
    logic        ready, e1, e2, lane;
    logic [31:0] f1, f2;
    logic [15:0] runs;

    logic        d4_rst, d4_valid, d4_flush, d4_rd1, d4_rd2;
    logic [31:0] d4_data;
    logic        d4_ready, d4_e1, d4_e2, d4_lane;
    logic [31:0] d4_f1, d4_f2;
    logic [15:0] d4_runs;

    int n_pass  = 0;
    int n_total = 0;
    int row_id  = 0;

    bonsai_run_loader #(.RUN_LEN(4), .DEPTH(16), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready),
        .i_flush(flush), .o_fifo_1(f1), .o_fifo_1_empty(e1), .i_fifo_1_read(rd1),
        .o_fifo_2(f2), .o_fifo_2_empty(e2), .i_fifo_2_read(rd2),
        .o_runs_done(runs), .o_lane(lane)
    );

    bonsai_run_loader #(.RUN_LEN(4), .DEPTH(4), .CNT_W(16)) u_dut4 (
        .i_clk(clk), .i_rst(d4_rst), .i_data(d4_data), .i_valid(d4_valid), .o_ready(d4_ready),
        .i_flush(d4_flush), .o_fifo_1(d4_f1), .o_fifo_1_empty(d4_e1), .i_fifo_1_read(d4_rd1),
        .o_fifo_2(d4_f2), .o_fifo_2_empty(d4_e2), .i_fifo_2_read(d4_rd2),
        .o_runs_done(d4_runs), .o_lane(d4_lane)
    );

    typedef struct {
        bit          rst;
        bit          vld;
        logic [31:0] dat;
        bit          fl;
        bit          r1;
        bit          r2;
        bit          rdy;
        bit          e1;
        bit          e2;
        int          runs;
        bit          lane;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit vl, logic [31:0] d, bit fl, bit p1, bit p2,
                               bit rdy, bit x1, bit x2, int rn, bit ln);
        vec_t t;
        t.rst = r; t.vld = vl; t.dat = d; t.fl = fl; t.r1 = p1; t.r2 = p2;
        t.rdy = rdy; t.e1 = x1; t.e2 = x2; t.runs = rn; t.lane = ln;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Applies each row after a falling edge, checks o_ready before the rising edge
    // and the registered outputs just after it.
    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; valid = tbl[i].vld; data = tbl[i].dat;
            flush = tbl[i].fl; rd1 = tbl[i].r1; rd2 = tbl[i].r2;
            #1;
            chk($sformatf("row%0d ready", row_id), {31'b0, ready}, {31'b0, tbl[i].rdy});
            @(posedge clk); #1;
            chk($sformatf("row%0d emptyA", row_id), {31'b0, e1}, {31'b0, tbl[i].e1});
            chk($sformatf("row%0d emptyB", row_id), {31'b0, e2}, {31'b0, tbl[i].e2});
            chk($sformatf("row%0d runs", row_id), {16'b0, runs}, tbl[i].runs);
            chk($sformatf("row%0d lane", row_id), {31'b0, lane}, {31'b0, tbl[i].lane});
            row_id++;
            @(negedge clk);
        end
        rst = 0; valid = 0; data = 0; flush = 0; rd1 = 0; rd2 = 0;
        tbl.delete();
    endtask

    function automatic logic get_empty(int sel);
        case (sel)
            0: return e1;
            1: return e2;
            2: return d4_e1;
            default: return d4_e2;
        endcase
    endfunction

    function automatic logic [31:0] get_head(int sel);
        case (sel)
            0: return f1;
            1: return f2;
            2: return d4_f1;
            default: return d4_f2;
        endcase
    endfunction

    task automatic set_rd(input int sel, input logic b);
        case (sel)
            0: rd1 = b;
            1: rd2 = b;
            2: d4_rd1 = b;
            default: d4_rd2 = b;
        endcase
    endtask

    // Pops n entries from a lane, checking each head, then checks the lane is empty.
    task automatic drain(input int sel, input int n, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] a4);
        logic [31:0] exp [5];
        exp[0] = a0; exp[1] = a1; exp[2] = a2; exp[3] = a3; exp[4] = a4;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("lane%0d pop%0d nonempty", sel, k), {31'b0, get_empty(sel)}, 32'd0);
            chk($sformatf("lane%0d pop%0d head", sel, k), get_head(sel), exp[k]);
            set_rd(sel, 1'b1);
            @(posedge clk);
            @(negedge clk);
            set_rd(sel, 1'b0);
        end
        #1;
        chk($sformatf("lane%0d drained", sel), {31'b0, get_empty(sel)}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; valid = 0; data = 0; flush = 0; rd1 = 0; rd2 = 0;
        d4_rst = 1; d4_valid = 0; d4_data = 0; d4_flush = 0; d4_rd1 = 0; d4_rd2 = 0;
        @(negedge clk);

        // Stream 1..8, continuous valid, no pops.
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,1,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,2,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,3,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,4,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,5,0,0,0, 0,0,1,1,1));
        tbl.push_back(v(0,1,5,0,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,1,6,0,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,1,7,0,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,1,8,0,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,0,2,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,0,0,2,0));
        run_tbl();
        drain(0, 5, 1, 2, 3, 4, 0);
        drain(1, 5, 5, 6, 7, 8, 0);

        // Explicit zero terminator ends a short run.
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,10,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,20,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,0,0,0,0, 1,0,1,1,1));
        tbl.push_back(v(0,1,30,0,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0, 1,0,0,1,1));
        run_tbl();
        drain(0, 3, 10, 20, 0, 0, 0);
        drain(1, 1, 30, 0, 0, 0, 0);

        // Flush with idle input, flush at count 0, flush together with a transfer.
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,5,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,6,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,0,0,1,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,1,1,1));
        tbl.push_back(v(0,0,0,1,0,0, 1,0,1,1,1));
        tbl.push_back(v(0,0,0,0,0,0, 1,0,1,1,1));
        tbl.push_back(v(0,1,9,1,0,0, 1,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,0,2,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,0,0,2,0));
        run_tbl();
        drain(0, 3, 5, 6, 0, 0, 0);
        drain(1, 2, 9, 0, 0, 0, 0);

        // Pop the empty lane B while writing lane A.
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,1,0,0,1, 1,0,1,0,0));
        tbl.push_back(v(0,1,0,0,0,0, 1,0,1,1,1));
        tbl.push_back(v(0,1,2,0,0,0, 1,0,0,1,1));
        run_tbl();
        drain(0, 2, 1, 0, 0, 0, 0);
        drain(1, 1, 2, 0, 0, 0, 0);

        // Reset mid-run discards the partial run.
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,1,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,2,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(1,0,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,1,7,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,8,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,9,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,1,10,0,0,0, 1,0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,1,1,1));
        tbl.push_back(v(0,0,0,0,0,0, 1,0,1,1,1));
        run_tbl();
        drain(0, 5, 7, 8, 9, 10, 0);
        chk("reset lane B empty", {31'b0, e2}, 32'd1);

        // DEPTH=4: full lane A holds the FSM in TERM until one pop.
        d4_rst = 0;
        for (int i = 1; i <= 4; i++) begin
            d4_valid = 1; d4_data = i;
            #1 chk($sformatf("d4 ready key%0d", i), {31'b0, d4_ready}, 32'd1);
            @(negedge clk);
        end
        d4_data = 5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("d4 stall%0d ready", i), {31'b0, d4_ready}, 32'd0);
            chk($sformatf("d4 stall%0d runs", i), {16'b0, d4_runs}, 32'd0);
            chk($sformatf("d4 stall%0d lane", i), {31'b0, d4_lane}, 32'd0);
            @(negedge clk);
        end
        d4_rd1 = 1;
        #1 chk("d4 pop-cycle ready", {31'b0, d4_ready}, 32'd0);
        @(negedge clk);
        d4_rd1 = 0;
        #1;
        chk("d4 term-write ready", {31'b0, d4_ready}, 32'd0);
        chk("d4 term-write runs", {16'b0, d4_runs}, 32'd0);
        @(negedge clk);
        #1;
        chk("d4 laneB ready", {31'b0, d4_ready}, 32'd1);
        chk("d4 laneB lane", {31'b0, d4_lane}, 32'd1);
        chk("d4 laneB runs", {16'b0, d4_runs}, 32'd1);
        @(negedge clk);
        d4_valid = 0;
        #1 chk("d4 laneB written", {31'b0, d4_e2}, 32'd0);
        @(negedge clk);
        drain(2, 4, 2, 3, 4, 0, 0);
        drain(3, 1, 5, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
